// File: rtl/uart_rx_if.sv
// UART receive bus: serial line in, received byte with strobe and error flags out.
interface uart_rx_if;
    logic       rxIn;
    logic [7:0] dataOut;
    logic       valid;
    logic       parityErr;
    logic       frameErr;

    // Line driver / byte consumer side.
    modport master (
        output rxIn,
        input  dataOut,
        input  valid,
        input  parityErr,
        input  frameErr
    );

    // Receiver side.
    modport slave (
        input  rxIn,
        output dataOut,
        output valid,
        output parityErr,
        output frameErr
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: start detect, 8 data bits LSB-first at mid-bit, optional
// parity, 1 or 2 stop bits, one-cycle valid strobe with error flags.
// Optional feature macro: UART_RX_SYNC_EN adds a two-flop input synchronizer
// (all sample points and valid move 2 cycles later).
module uart_rx #(
    parameter int unsigned PRESCALER_COUNT = 234,
    parameter logic [1:0]  PARITY          = 2'b00,
    parameter logic        STOP_BITS       = 1'b0
) (
    input  logic     clk,
    input  logic     rst_n,
    uart_rx_if.slave rx_bus
);

    localparam int unsigned     CNT_W      = $clog2(PRESCALER_COUNT) + 1;
    localparam int unsigned     HALF       = PRESCALER_COUNT / 2;
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALER_COUNT - 1);
    localparam logic            PARITY_EN  = (PARITY == 2'b01) || (PARITY == 2'b10);
    localparam logic            PARITY_ODD = (PARITY == 2'b01);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             perr_q, perr_d;
    logic             ferr_q, ferr_d;
    logic             armed_q, armed_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             perr_out_q, perr_out_d;
    logic             ferr_out_q, ferr_out_d;

    logic rx_s;
    logic half_c;
    logic tick_c;
    logic exp_par_c;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer on the asynchronous RX pin, idling high.
    always_ff @(posedge clk) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx_bus.rxIn};
    end
    assign rx_s = sync_q[1];
`else
    assign rx_s = rx_bus.rxIn;
`endif

    assign half_c    = (cnt_q == CNT_HALF);
    assign tick_c    = (cnt_q == CNT_LAST);
    assign exp_par_c = PARITY_ODD ? ~^shift_q : ^shift_q;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (armed_q && !rx_s) state_d = S_START;
            S_START:  if (half_c) state_d = rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (tick_c && (bit_cnt_q == 3'd7))
                          state_d = PARITY_EN ? S_PARITY : S_STOP;
            S_PARITY: if (tick_c) state_d = S_STOP;
            S_STOP:   if (tick_c && (!STOP_BITS || (bit_cnt_q == 3'd1)))
                          state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values per state.
    always_comb begin
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        armed_d    = armed_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        perr_out_d = perr_out_q;
        ferr_out_d = ferr_out_q;
        case (state_q)
            S_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = '0;
                perr_d    = 1'b0;
                ferr_d    = 1'b0;
                if (rx_s) armed_d = 1'b1;
            end
            S_START: cnt_d = half_c ? '0 : cnt_q + CNT_W'(1);
            S_DATA: begin
                cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                if (tick_c) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_PARITY: begin
                cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                if (tick_c && (rx_s != exp_par_c)) perr_d = 1'b1;
            end
            S_STOP: begin
                cnt_d = tick_c ? '0 : cnt_q + CNT_W'(1);
                if (tick_c) begin
                    if (!rx_s) ferr_d = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                data_d     = shift_q;
                perr_out_d = perr_q;
                ferr_out_d = ferr_q;
                valid_d    = 1'b1;
                if (ferr_q) armed_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            armed_q    <= 1'b1;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            perr_out_q <= 1'b0;
            ferr_out_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            armed_q    <= armed_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_out_q <= perr_out_d;
            ferr_out_q <= ferr_out_d;
        end
    end

    assign rx_bus.dataOut   = data_q;
    assign rx_bus.valid     = valid_q;
    assign rx_bus.parityErr = perr_out_q;
    assign rx_bus.frameErr  = ferr_out_q;

endmodule
